// File: rtl/rvm_axi_pkg.sv
// Shared definitions for the AXI4 SRAM subordinate: response codes, the
// transfer size it serves, and the slave state encoding.
package rvm_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RD_MEM     = 3'd1;
    localparam logic [2:0] ST_RD_CAP     = 3'd2;
    localparam logic [2:0] ST_RD_RESP    = 3'd3;
    localparam logic [2:0] ST_WR_COLLECT = 3'd4;
    localparam logic [2:0] ST_WR_MEM     = 3'd5;
    localparam logic [2:0] ST_WR_RESP    = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        RD_MEM     = ST_RD_MEM,
        RD_CAP     = ST_RD_CAP,
        RD_RESP    = ST_RD_RESP,
        WR_COLLECT = ST_WR_COLLECT,
        WR_MEM     = ST_WR_MEM,
        WR_RESP    = ST_WR_RESP
    } slave_state_e;

endpackage

// File: rtl/rvm_axi4_sram_slave_if.sv
// Single-beat AXI4 channel bundle (AR/R/AW/W/B) between a master and the
// SRAM subordinate.
interface rvm_axi4_sram_slave_if;

    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 single-beat subordinate in front of a synchronous single-port SRAM.
// Define RVM_AXI_SLAVE_ERR_EN to return SLVERR for out-of-range or non-word accesses.
module rvm_axi4_sram_slave
    import rvm_axi_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    rvm_axi4_sram_slave_if.slave  s_axi,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [MEM_AW-1:0]     sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    // BASE_ADDR is aligned to the SRAM size, so the word index is a plain bit-slice difference.
    function automatic logic [MEM_AW-1:0] word_addr(input logic [31:0] addr);
        return addr[MEM_AW+1:2] - BASE_ADDR[MEM_AW+1:2];
    endfunction

`ifdef RVM_AXI_SLAVE_ERR_EN
    function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ((off >> (MEM_AW + 2)) != 32'd0) || (size != SIZE_WORD) || (addr[1:0] != 2'b00);
    endfunction
`endif

    slave_state_e state_r;
    slave_state_e next_state_s;

    logic ar_hs_s, aw_hs_s, w_hs_s;
    logic aw_have_s, w_have_s;
    logic ar_err_s, aw_err_s, wr_err_s;

    logic              aw_got_r, w_got_r, aw_err_r;
    logic [MEM_AW-1:0] waddr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;

    logic [MEM_AW-1:0] wr_addr_s;
    logic [31:0]       wr_data_s;
    logic [3:0]        wr_strb_s;

    logic [31:0]       rdata_r;
    logic [1:0]        rresp_r, bresp_r;
    logic              rvalid_r, bvalid_r;
    logic              sram_cs_r, sram_we_r;
    logic [3:0]        sram_be_r;
    logic [MEM_AW-1:0] sram_addr_r;
    logic [31:0]       sram_wdata_r;

`ifdef RVM_AXI_SLAVE_ERR_EN
    assign ar_err_s = addr_err(s_axi.araddr, s_axi.arsize);
    assign aw_err_s = addr_err(s_axi.awaddr, s_axi.awsize);
`else
    logic unused_cfg_s;
    assign ar_err_s     = 1'b0;
    assign aw_err_s     = 1'b0;
    assign unused_cfg_s = ^{s_axi.arsize, s_axi.awsize, s_axi.araddr[1:0], s_axi.awaddr[1:0],
                            s_axi.araddr[31:MEM_AW+2], s_axi.awaddr[31:MEM_AW+2]};
`endif

    // READY decode: reads win in IDLE; in WR_COLLECT only the missing channel is open.
    always_comb begin
        s_axi.arready = 1'b0;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        case (state_r)
            IDLE: begin
                s_axi.arready = !ARESET;
                s_axi.awready = !ARESET && !s_axi.arvalid;
                s_axi.wready  = !ARESET && !s_axi.arvalid;
            end
            WR_COLLECT: begin
                s_axi.awready = !aw_got_r;
                s_axi.wready  = !w_got_r;
            end
            default: begin
                s_axi.arready = 1'b0;
            end
        endcase
    end

    assign ar_hs_s   = s_axi.arvalid && s_axi.arready;
    assign aw_hs_s   = s_axi.awvalid && s_axi.awready;
    assign w_hs_s    = s_axi.wvalid  && s_axi.wready;
    assign aw_have_s = aw_got_r || aw_hs_s;
    assign w_have_s  = w_got_r  || w_hs_s;
    assign wr_err_s  = aw_hs_s ? aw_err_s : aw_err_r;
    assign wr_addr_s = aw_hs_s ? word_addr(s_axi.awaddr) : waddr_r;
    assign wr_data_s = w_hs_s  ? s_axi.wdata : wdata_r;
    assign wr_strb_s = w_hs_s  ? s_axi.wstrb : wstrb_r;

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    next_state_s = ar_err_s ? RD_RESP : RD_MEM;
                end else if (aw_hs_s || w_hs_s) begin
                    if (aw_have_s && w_have_s) begin
                        next_state_s = wr_err_s ? WR_RESP : WR_MEM;
                    end else begin
                        next_state_s = WR_COLLECT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_COLLECT: begin
                if (aw_have_s && w_have_s) begin
                    next_state_s = wr_err_s ? WR_RESP : WR_MEM;
                end else begin
                    next_state_s = WR_COLLECT;
                end
            end
            RD_MEM:  next_state_s = RD_CAP;
            RD_CAP:  next_state_s = RD_RESP;
            RD_RESP: next_state_s = s_axi.rready ? IDLE : RD_RESP;
            WR_MEM:  next_state_s = WR_RESP;
            WR_RESP: next_state_s = s_axi.bready ? IDLE : WR_RESP;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus write-channel latches held while one half is outstanding.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r  <= IDLE;
            aw_got_r <= 1'b0;
            w_got_r  <= 1'b0;
            aw_err_r <= 1'b0;
            waddr_r  <= '0;
            wdata_r  <= 32'h0;
            wstrb_r  <= 4'h0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == WR_COLLECT) begin
                if (aw_hs_s) begin
                    aw_got_r <= 1'b1;
                    aw_err_r <= aw_err_s;
                    waddr_r  <= word_addr(s_axi.awaddr);
                end
                if (w_hs_s) begin
                    w_got_r <= 1'b1;
                    wdata_r <= s_axi.wdata;
                    wstrb_r <= s_axi.wstrb;
                end
            end else begin
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
            end
        end
    end

    // SRAM strobes and AXI response registers, loaded from the state being entered.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sram_cs_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            sram_be_r    <= 4'h0;
            sram_addr_r  <= '0;
            sram_wdata_r <= 32'h0;
            rdata_r      <= 32'h0;
            rresp_r      <= RESP_OKAY;
            rvalid_r     <= 1'b0;
            bresp_r      <= RESP_OKAY;
            bvalid_r     <= 1'b0;
        end else begin
            sram_cs_r <= (next_state_s == RD_MEM) || (next_state_s == WR_MEM);
            sram_we_r <= (next_state_s == WR_MEM);
            sram_be_r <= (next_state_s == WR_MEM) ? wr_strb_s : 4'h0;
            if (next_state_s == RD_MEM) begin
                sram_addr_r <= word_addr(s_axi.araddr);
            end else if (next_state_s == WR_MEM) begin
                sram_addr_r  <= wr_addr_s;
                sram_wdata_r <= wr_data_s;
            end
            // Error reads bypass RD_CAP, so the zero loaded here is what they return.
            if (ar_hs_s) begin
                rresp_r <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
                rdata_r <= 32'h0;
            end else if (state_r == RD_CAP) begin
                rdata_r <= sram_rdata;
            end
            if (((state_r == IDLE) || (state_r == WR_COLLECT)) && aw_have_s && w_have_s) begin
                bresp_r <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
            end
            rvalid_r <= (next_state_s == RD_RESP);
            bvalid_r <= (next_state_s == WR_RESP);
        end
    end

    assign sram_cs      = sram_cs_r;
    assign sram_we      = sram_we_r;
    assign sram_be      = sram_be_r;
    assign sram_addr    = sram_addr_r;
    assign sram_wdata   = sram_wdata_r;
    assign s_axi.rdata  = rdata_r;
    assign s_axi.rresp  = rresp_r;
    assign s_axi.rvalid = rvalid_r;
    assign s_axi.bresp  = bresp_r;
    assign s_axi.bvalid = bvalid_r;

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
// Scoreboard bench for rvm_axi4_sram_slave: expected SRAM writes, R and B
// responses are queued at stimulus time and checked as the DUT produces them.
module tb_rvm_axi4_sram_slave;
    import rvm_axi_pkg::*;

    localparam int MEM_AW = 10;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    rvm_axi4_sram_slave_if bus ();

    logic              sram_cs, sram_we;
    logic [3:0]        sram_be;
    logic [MEM_AW-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    rvm_axi4_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h0000_0000)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_exp_t;

    int vectors = 0;
    int miscompares = 0;
    int cs_count = 0;

    logic [31:0] sram_mem [0:(1<<MEM_AW)-1];
    logic [31:0] ref_mem  [0:(1<<MEM_AW)-1];
    wr_exp_t     wr_q [$];
    logic [33:0] rd_q [$];
    logic [1:0]  b_q  [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // SRAM model: byte-enabled write, read data one cycle after the select.
    always @(posedge ACLK) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    always @(negedge ACLK) begin : monitor
        wr_exp_t     ew;
        logic [33:0] er;
        logic [1:0]  eb;
        if (!ARESET) begin
            if (sram_cs) cs_count++;
            if (sram_cs && sram_we) begin
                if (wr_q.size() == 0) check_val("unexpected_sram_write", 32'd1, 32'd0);
                else begin
                    ew = wr_q.pop_front();
                    check_val("sram_addr", 32'(sram_addr), 32'(ew.addr));
                    check_val("sram_wdata", sram_wdata, ew.data);
                    check_val("sram_be", 32'(sram_be), 32'(ew.be));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rd_q.size() == 0) check_val("unexpected_r", 32'd1, 32'd0);
                else begin
                    er = rd_q.pop_front();
                    check_val("rdata", bus.rdata, er[31:0]);
                    check_val("rresp", 32'(bus.rresp), 32'(er[33:32]));
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) check_val("unexpected_b", 32'd1, 32'd0);
                else begin
                    eb = b_q.pop_front();
                    check_val("bresp", 32'(bus.bresp), 32'(eb));
                end
            end
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [MEM_AW-1:0] idx;
        idx = addr[MEM_AW+1:2];
        wr_q.push_back('{addr: idx, data: data, be: strb});
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        b_q.push_back(RESP_OKAY);
    endtask

    task automatic expect_read(input logic [31:0] addr);
        logic [MEM_AW-1:0] idx;
        idx = addr[MEM_AW+1:2];
        rd_q.push_back({RESP_OKAY, ref_mem[idx]});
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return bus.rvalid;
            1:       return bus.bvalid;
            default: return bus.awready && bus.wready;
        endcase
    endfunction

    // Counts cycles (current one is 1) until the selected signal is seen at a negedge.
    task automatic wait_sig(input string tag, input int which, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ACLK);
            if (sig_sel(which)) begin
                n = i;
                break;
            end
            tick();
        end
        if (n == 0) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int exp_lat);
        int n;
        bus.araddr = addr; bus.arsize = SIZE_WORD; bus.arvalid = 1'b1;
        @(negedge ACLK);
        check_val("arready_idle", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
        wait_sig("rvalid", 0, n);
        check_val("read_latency", 32'(n), 32'(exp_lat));
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        bus.awaddr = addr; bus.awsize = SIZE_WORD; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        @(negedge ACLK);
        check_val("aw_w_ready", 32'({bus.awready, bus.wready}), 32'd3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_sig("bvalid", 1, n);
        check_val("write_latency", 32'(n), 32'd2);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cs0;
        for (int i = 0; i < (1 << MEM_AW); i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        sram_rdata  = 32'h0;
        bus.araddr  = 32'h0; bus.arsize = SIZE_WORD; bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awaddr  = 32'h0; bus.awsize = SIZE_WORD; bus.awvalid = 1'b0;
        bus.wdata   = 32'h0; bus.wstrb  = 4'h0;      bus.wvalid  = 1'b0; bus.bready = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge ACLK);
        check_val("rst_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        check_val("rst_valid", 32'({bus.rvalid, bus.bvalid}), 32'd0);
        check_val("rst_sram_ctl", 32'({sram_cs, sram_we, sram_be}), 32'd0);
        check_val("rst_sram_addr", 32'(sram_addr), 32'd0);
        check_val("rst_sram_wdata", sram_wdata, 32'd0);
        check_val("rst_rdata", bus.rdata, 32'd0);
        check_val("rst_resp", 32'({bus.rresp, bus.bresp}), 32'd0);
        tick();
        ARESET = 1'b0;
        tick();

        // AW and W together
        expect_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        check_val("t2_ready", 32'({bus.awready, bus.wready}), 32'd3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge ACLK);
        check_val("t2_cs_we", 32'({sram_cs, sram_we}), 32'd3);
        check_val("t2_addr", 32'(sram_addr), 32'd4);
        tick();
        @(negedge ACLK);
        check_val("t2_bvalid", 32'(bus.bvalid), 32'd1);
        tick();

        // W three cycles ahead of AW, merged by byte strobes
        expect_write(32'h14, 32'hAAAA_AAAA, 4'hF);
        do_write(32'h14, 32'hAAAA_AAAA, 4'hF);
        expect_write(32'h14, 32'h1234_5678, 4'b0011);
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'b0011; bus.wvalid = 1'b1;
        @(negedge ACLK);
        check_val("t3_wready_first", 32'(bus.wready), 32'd1);
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check_val("t3_collect_ready", 32'({bus.awready, bus.wready}), 32'd2);
            check_val("t3_no_cs", 32'(sram_cs), 32'd0);
            tick();
        end
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        @(negedge ACLK);
        check_val("t3_awready", 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
        wait_sig("t3_bvalid", 1, n);
        check_val("t3_write_latency", 32'(n), 32'd2);
        tick();
        check_val("t3_ref_merge", ref_mem[5], 32'hAAAA_5678);
        expect_read(32'h14);
        do_read(32'h14, 3);

        // Simultaneous read and write: read first
        expect_read(32'h10);
        expect_write(32'h20, 32'hCAFE_F00D, 4'hF);
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        check_val("t4_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd4);
        tick();
        bus.arvalid = 1'b0;
        wait_sig("t4_awready", 2, n);
        check_val("t4_write_wait", 32'(n), 32'd4);
        check_val("t4_read_done", 32'(rd_q.size()), 32'd0);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_sig("t4_bvalid", 1, n);
        check_val("t4_write_latency", 32'(n), 32'd2);
        tick();

        // R backpressure
        bus.rready = 1'b0;
        expect_read(32'h10);
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        wait_sig("t5_rvalid", 0, n);
        check_val("t5_latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge ACLK);
            check_val("t5_rvalid_hold", 32'(bus.rvalid), 32'd1);
            check_val("t5_rdata_hold", bus.rdata, 32'hDEAD_BEEF);
            check_val("t5_arready_low", 32'(bus.arready), 32'd0);
        end
        tick();
        bus.rready = 1'b1;
        @(negedge ACLK);
        tick();

        // Address beyond the SRAM
        expect_write(32'h0, 32'h0BAD_F00D, 4'hF);
        do_write(32'h0, 32'h0BAD_F00D, 4'hF);
        cs0 = cs_count;
`ifdef RVM_AXI_SLAVE_ERR_EN
        rd_q.push_back({RESP_SLVERR, 32'h0});
        do_read(32'h0000_1000, 1);
        check_val("t6_no_cs", 32'(cs_count), 32'(cs0));
`else
        rd_q.push_back({RESP_OKAY, 32'h0BAD_F00D});
        do_read(32'h0000_1000, 3);
        check_val("t6_one_cs", 32'(cs_count), 32'(cs0 + 1));
`endif

        // Zero strobes still cycle the SRAM
        expect_write(32'h24, 32'hFFFF_FFFF, 4'h0);
        do_write(32'h24, 32'hFFFF_FFFF, 4'h0);
        expect_read(32'h24);
        do_read(32'h24, 3);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            a = 32'($urandom_range(1, (1 << MEM_AW) - 1)) << 2;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            expect_write(a, d, s);
            do_write(a, d, s);
            expect_read(a);
            do_read(a, 3);
        end

        // Reset right after a write handshake
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'h5555_5555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        ARESET = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge ACLK);
        check_val("t7_no_we", 32'({sram_cs, sram_we}), 32'd0);
        check_val("t7_no_bvalid", 32'(bus.bvalid), 32'd0);
        tick();
        @(negedge ACLK);
        tick();
        ARESET = 1'b0;
        expect_read(32'h10);
        do_read(32'h10, 3);

        check_val("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check_val("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check_val("b_q_empty", 32'(b_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rvm_axi4_sram_slave.md
# rvm_axi4_sram_slave

AXI4 subordinate (responder) that terminates the single-beat, 32-bit AXI4 transactions issued by the core's AXI4 master and turns them into accesses on a synchronous single-port SRAM. It sits between the system interconnect and on-chip instruction/data RAM, handles one outstanding transaction at a time, and fully honours R/B channel backpressure.

## Interface
- MEM_AW, 10: SRAM word-address width; memory holds 2^MEM_AW 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of SRAM word 0; must be aligned to 4*2^MEM_AW.

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_ARADDR/ARSIZE/ARVALID  in  32/3/1  read address channel; ARREADY  out  1.
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel; RREADY  in  1.
- S_AXI_AWADDR/AWSIZE/AWVALID  in  32/3/1  write address channel; AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel; WREADY  out  1.
- S_AXI_BRESP/BVALID  out  2/1  write response; BREADY  in  1.
- sram_cs  out  1  SRAM chip select, one cycle per access.
- sram_we  out  1  write enable, valid with sram_cs.
- sram_be  out  4  byte enables (from WSTRB).
- sram_addr  out  MEM_AW  word address = (ADDR - BASE_ADDR)[MEM_AW+1:2].
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data, valid the cycle after sram_cs && !sram_we.

## Operation
- States: IDLE, RD_MEM, RD_CAP, RD_RESP, WR_COLLECT, WR_MEM, WR_RESP.
- IDLE: ARREADY=1. AWREADY=WREADY=!ARVALID. ARVALID wins when both AR and AW/W are valid in the same cycle (read priority).
- AR handshake: latch ARADDR/ARSIZE -> RD_MEM (sram_cs=1, sram_we=0) -> RD_CAP (sram_rdata into rdata register) -> RD_RESP (RVALID=1, held stable until RREADY) -> IDLE.
- AW and/or W handshake from IDLE: latch the accepted channel(s). Both accepted -> WR_MEM. Otherwise -> WR_COLLECT, where only the missing channel's READY is high; the other READY is 0.
- WR_MEM: sram_cs=1, sram_we=1, sram_be=latched WSTRB, sram_wdata=latched WDATA -> WR_RESP (BVALID=1 until BREADY) -> IDLE.
- WSTRB=4'b0000 still performs the SRAM cycle with sram_be=0 and returns OKAY.
- Only one transaction is in flight. All READYs are 0 outside IDLE/WR_COLLECT.
- RRESP/BRESP are OKAY (2'b00) unless an error is flagged (see Configuration).
- Error accesses skip the SRAM cycle (no sram_cs) and go directly to RD_RESP/WR_RESP. RDATA=32'h0 on a read error.

## Timing
- Reset values: all READY/VALID=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0, RDATA=0, RRESP/BRESP=0. State=IDLE.
- Read: AR handshake in cycle T -> sram_cs in T+1 -> RVALID in T+3 (3-cycle latency). With RREADY=1, the next ARREADY comes in T+4.
- Write, AW and W in the same cycle T: sram_cs/we in T+1 -> BVALID in T+2. If W arrives k cycles after AW, every step shifts by k (and symmetrically when AW lags).
- Error access: RVALID/BVALID one cycle after the final handshake.
- ARESET asserted mid-transaction: immediately aborts to IDLE and drops all VALIDs and sram_cs. No partial SRAM write is issued after reset assertion.
- sram_* outputs are registered. READY outputs are combinational from state and ARVALID only.

## Configuration
- RVM_AXI_SLAVE_ERR_EN defined: an access returns SLVERR (2'b10) when either of the following holds:
  - the address lies outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AW);
  - AxSIZE != 3'b010, or ADDR[1:0] != 0.
- RVM_AXI_SLAVE_ERR_EN undefined: no checks are made. The address is taken modulo the SRAM size, ADDR[1:0] and AxSIZE are ignored, and the response is always OKAY.

## Structure
- Shared package rvm_axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, SIZE_WORD=3'b010;
  - the slave state encoding (3-bit localparams).
- Single flat module; no sub-module is warranted, since the FSM, address latch and response registers are all small.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x10 with WSTRB=4'hF and AW/W together: sram_cs/we one cycle after the handshake, sram_addr=4, BVALID two cycles after, BRESP=0.
- W presented 3 cycles before AW (addr 0x14, data 32'h12345678, WSTRB=4'b0011): WREADY asserts first, then AWREADY, then a single SRAM write with sram_be=4'b0011. A later read of 0x14 returns RVALID 3 cycles after AR with the SRAM model's merged data.
- ARVALID and AWVALID+WVALID raised in the same cycle: the read completes first. The write is accepted only after RVALID&&RREADY.
- RREADY held low for 5 cycles: RVALID and RDATA stay stable. ARREADY stays 0 until the R handshake.
- With RVM_AXI_SLAVE_ERR_EN, read 0x0000_1000 when MEM_AW=10: no sram_cs, RRESP=2'b10, RDATA=0. Without the macro, the same read hits word 0 with OKAY.
- ARESET pulsed the cycle after a write handshake: no sram_we observed, BVALID=0, and the block accepts a new AR in the first cycle after reset deasserts.
